// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions,
// exception codes and the exception-controller state type.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_IM_LO  = 10;
  localparam int SR_IM_HI  = 15;

  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } exc_state_e;

endpackage

// File: rtl/exc_ctrl_if.sv
// M-stage / interrupt-line connection between the pipeline and the
// exception controller.
interface exc_ctrl_if;
  logic [5:0]  hwint;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [4:0]  m_exc_code;
  logic        m_eret;
  logic        m_cp0_we;
  logic [4:0]  m_cp0_addr;
  logic [31:0] m_cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        take;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;
  logic        exl;

  modport master (
    output hwint, m_valid, m_pc, m_bd, m_exc_code, m_eret,
           m_cp0_we, m_cp0_addr, m_cp0_wdata,
    input  cp0_rdata, take, handler_pc, epc_out, exl
  );

  modport slave (
    input  hwint, m_valid, m_pc, m_bd, m_exc_code, m_eret,
           m_cp0_we, m_cp0_addr, m_cp0_wdata,
    output cp0_rdata, take, handler_pc, epc_out, exl
  );
endinterface

// File: rtl/cp0_regs.sv
// CP0 register storage (SR.IM/IE, Cause, EPC) with mtc0 writes and
// zero-latency mfc0 reads. SR.EXL lives in the controller FSM.
module cp0_regs
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h4D49_5053
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hwint,
  input  logic        take,
  input  logic        int_sel,
  input  logic [31:2] m_pc,
  input  logic        m_bd,
  input  logic [4:0]  m_exc_code,
  input  logic        m_cp0_we,
  input  logic [4:0]  m_cp0_addr,
  input  logic [31:0] m_cp0_wdata,
  input  logic        exl,
  output logic [31:0] cp0_rdata,
  output logic [5:0]  im,
  output logic        ie,
  output logic [31:0] epc
);

  logic [5:0]  ip_q;
  logic        bd_q;
  logic [4:0]  exc_q;
  logic [31:0] epc_take;

  assign epc_take = m_bd ? ({m_pc, 2'b00} - 32'd4) : {m_pc, 2'b00};

  // A taken exception flushes the M-stage instruction, so its mtc0 is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      im    <= 6'h3F;
      ie    <= 1'b1;
      ip_q  <= 6'h00;
      bd_q  <= 1'b0;
      exc_q <= EXC_INT;
      epc   <= 32'h0;
    end else begin
      ip_q <= hwint;
      if (take) begin
        bd_q  <= m_bd;
        exc_q <= int_sel ? EXC_INT : m_exc_code;
        epc   <= epc_take;
      end else if (m_cp0_we) begin
        case (m_cp0_addr)
          CP0_SR: begin
            im <= m_cp0_wdata[SR_IM_HI:SR_IM_LO];
            ie <= m_cp0_wdata[SR_IE];
          end
          CP0_EPC: epc <= {m_cp0_wdata[31:2], 2'b00};
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cp0_rdata = 32'h0;
    case (m_cp0_addr)
      CP0_SR: begin
        cp0_rdata[SR_IM_HI:SR_IM_LO] = im;
        cp0_rdata[SR_EXL]            = exl;
        cp0_rdata[SR_IE]             = ie;
      end
      CP0_CAUSE: begin
        cp0_rdata[CAUSE_BD]                  = bd_q;
        cp0_rdata[CAUSE_IP_HI:CAUSE_IP_LO]   = ip_q;
        cp0_rdata[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_q;
      end
      CP0_EPC:  cp0_rdata = epc;
      CP0_PRID: cp0_rdata = PRID_VAL;
      default:  cp0_rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: arbitration, handler-mode FSM, EPC forwarding.
//   state   | meaning
//   RUN     | normal execution, SR.EXL = 0, exceptions and interrupts accepted
//   HANDLER | in handler, SR.EXL = 1, new requests ignored until eret
module exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL   = 32'h4D49_5053
) (
  input  logic       clk,
  input  logic       reset,
  exc_ctrl_if.slave  bus
);

  exc_state_e  state_q, state_d;
  logic        exl_q;
  logic [5:0]  im;
  logic        ie;
  logic [31:0] epc;
  logic        int_req, exc_req, take;
  logic        sr_wr, epc_wr;

  assign exl_q   = (state_q == HANDLER);
  assign int_req = (|(bus.hwint & im)) & ie & ~exl_q & bus.m_valid;
  assign exc_req = (bus.m_exc_code != EXC_INT) & ~exl_q & bus.m_valid;
  assign take    = (int_req | exc_req) & ~reset;
  assign sr_wr   = bus.m_cp0_we & (bus.m_cp0_addr == CP0_SR);
  assign epc_wr  = bus.m_cp0_we & (bus.m_cp0_addr == CP0_EPC);

  always_comb begin
    state_d = state_q;
    if (take)
      state_d = HANDLER;
    else if (sr_wr)
      state_d = bus.m_cp0_wdata[SR_EXL] ? HANDLER : RUN;
    else if (bus.m_eret & bus.m_valid)
      state_d = RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  cp0_regs #(.PRID_VAL(PRID_VAL)) u_cp0_regs (
    .clk         (clk),
    .reset       (reset),
    .hwint       (bus.hwint),
    .take        (take),
    .int_sel     (int_req),
    .m_pc        (bus.m_pc[31:2]),
    .m_bd        (bus.m_bd),
    .m_exc_code  (bus.m_exc_code),
    .m_cp0_we    (bus.m_cp0_we),
    .m_cp0_addr  (bus.m_cp0_addr),
    .m_cp0_wdata (bus.m_cp0_wdata),
    .exl         (exl_q),
    .cp0_rdata   (bus.cp0_rdata),
    .im          (im),
    .ie          (ie),
    .epc         (epc)
  );

  // The D-stage eret sees an EPC being written by the mtc0 currently in M.
  assign bus.epc_out    = epc_wr ? {bus.m_cp0_wdata[31:2], 2'b00} : epc;
  assign bus.take       = take;
  assign bus.handler_pc = HANDLER_PC;
  assign bus.exl        = exl_q;

endmodule
